// File: rtl/mc_controller.sv
// Multicycle control FSM for an RV32I subset (lw, sw, R-type, I-type ALU, beq, jal)
// driving a shared-memory, single-ALU datapath with a MemReady memory handshake.
module mc_controller #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [6:0]         op,
    input  logic               Zero,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [2:0]         ImmSrc,
    output logic               RegWrite,
    output logic               Retire,
    output logic               IllegalInstr,
    output logic [STATE_W-1:0] StateDbg
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    state_t      state_q, state_d;
    logic        pc_update_s, branch_s;
    logic        adr_src_s, mem_read_s, mem_write_s, ir_write_s;
    logic        reg_write_s, retire_s, illegal_s;
    logic [1:0]  result_src_s, alu_src_a_s, alu_src_b_s, alu_op_s;

    function automatic logic [2:0] imm_sel(input logic [6:0] opc);
        logic [2:0] sel;
        case (opc)
            OP_SW:   sel = 3'b001;
            OP_BEQ:  sel = 3'b010;
            OP_JAL:  sel = 3'b011;
            default: sel = 3'b000;
        endcase
        return sel;
    endfunction

    // State register; reset parks the machine in FETCH.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and per-state control outputs.
    always_comb begin
        state_d      = state_q;
        pc_update_s  = 1'b0;
        branch_s     = 1'b0;
        adr_src_s    = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        retire_s     = 1'b0;
        illegal_s    = 1'b0;
        result_src_s = 2'b00;
        alu_src_a_s  = 2'b00;
        alu_src_b_s  = 2'b00;
        alu_op_s     = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_read_s   = 1'b1;
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
                ir_write_s   = MemReady;
                pc_update_s  = MemReady;
                if (MemReady) begin
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                if (op == OP_LW) begin
                    state_d = S_MEMREAD;
                end else begin
                    state_d = S_MEMWRITE;
                end
            end
            S_MEMREAD: begin
                adr_src_s  = 1'b1;
                mem_read_s = 1'b1;
                if (MemReady) begin
                    state_d = S_MEMWB;
                end else begin
                    state_d = S_MEMREAD;
                end
            end
            S_MEMWB: begin
                result_src_s = 2'b01;
                reg_write_s  = 1'b1;
                retire_s     = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src_s   = 1'b1;
                mem_write_s = 1'b1;
                retire_s    = MemReady;
                if (MemReady) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_MEMWRITE;
                end
            end
            S_EXECR: begin
                alu_src_a_s = 2'b10;
                alu_op_s    = 2'b10;
                state_d     = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                alu_op_s    = 2'b10;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
                retire_s    = 1'b1;
                state_d     = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a_s = 2'b10;
                alu_op_s    = 2'b01;
                branch_s    = 1'b1;
                retire_s    = 1'b1;
                state_d     = S_FETCH;
            end
            S_JAL: begin
                // PC takes the target computed in DECODE; ALUWB then writes OldPC+4.
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b10;
                pc_update_s = 1'b1;
                state_d     = S_ALUWB;
            end
            S_TRAP: begin
                illegal_s = 1'b1;
                state_d   = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Every output is forced low while reset is held, so an abort is immediate.
    assign PCWrite      = resetn & (pc_update_s | (branch_s & Zero));
    assign AdrSrc       = resetn & adr_src_s;
    assign MemRead      = resetn & mem_read_s;
    assign MemWrite     = resetn & mem_write_s;
    assign IRWrite      = resetn & ir_write_s;
    assign RegWrite     = resetn & reg_write_s;
    assign Retire       = resetn & retire_s;
    assign IllegalInstr = resetn & illegal_s;
    assign ResultSrc    = resetn ? result_src_s : 2'b00;
    assign ALUSrcA      = resetn ? alu_src_a_s  : 2'b00;
    assign ALUSrcB      = resetn ? alu_src_b_s  : 2'b00;
    assign ALUOp        = resetn ? alu_op_s     : 2'b00;
    assign ImmSrc       = resetn ? imm_sel(op)  : 3'b000;
    assign StateDbg     = resetn ? STATE_W'(state_q) : {STATE_W{1'b0}};

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: instruction sequences, memory wait states,
// branch outcome, trap lock-up and mid-instruction reset abort.
module tb_mc_controller;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BAD  = 7'b1110011;

    logic       clk = 1'b0;
    logic       resetn;
    logic [6:0] op;
    logic       Zero, MemReady;
    logic       PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite, Retire, IllegalInstr;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [2:0] ImmSrc;
    logic [3:0] StateDbg;

    int n_checks = 0;
    int n_errors = 0;
    int n_retire = 0;
    int n_memwrite = 0;
    int n_irwrite = 0;

    mc_controller #(.STATE_W(4)) dut (
        .clk(clk), .resetn(resetn), .op(op), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .ImmSrc(ImmSrc), .RegWrite(RegWrite), .Retire(Retire),
        .IllegalInstr(IllegalInstr), .StateDbg(StateDbg)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the expected state, advance.
    task automatic cyc(input logic [6:0] o, input logic mr, input logic z,
                       input logic [3:0] st, input logic rt, input logic pcw);
        logic [1:0] exp_aluop;
        op = o; MemReady = mr; Zero = z;
        #1;
        exp_aluop = (st == 4'd9) ? 2'b01 : ((st == 4'd6 || st == 4'd7) ? 2'b10 : 2'b00);
        check_eq("state",    32'(StateDbg),     32'(st));
        check_eq("retire",   32'(Retire),       32'(rt));
        check_eq("pcwrite",  32'(PCWrite),      32'(pcw));
        check_eq("irwrite",  32'(IRWrite),      32'(st == 4'd0 && mr));
        check_eq("regwrite", 32'(RegWrite),     32'(st == 4'd4 || st == 4'd8));
        check_eq("memread",  32'(MemRead),      32'(st == 4'd0 || st == 4'd3));
        check_eq("memwrite", 32'(MemWrite),     32'(st == 4'd5));
        check_eq("adrsrc",   32'(AdrSrc),       32'(st == 4'd3 || st == 4'd5));
        check_eq("illegal",  32'(IllegalInstr), 32'(st == 4'd11));
        check_eq("aluop",    32'(ALUOp),        32'(exp_aluop));
        if (Retire)   n_retire++;
        if (MemWrite) n_memwrite++;
        if (IRWrite)  n_irwrite++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_en"}, 32'({PCWrite, MemRead, MemWrite, IRWrite, RegWrite, Retire, IllegalInstr}), 32'd0);
        check_eq({tag, "_st"}, 32'(StateDbg), 32'd0);
        check_eq({tag, "_mux"}, 32'({AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc}), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int retire_before;
        resetn = 1'b0; op = OP_SW; Zero = 1'b1; MemReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_reset_outputs("reset");
        end
        resetn = 1'b1;

        // Back-to-back R, I, lw, sw, jal with memory always ready.
        cyc(OP_R,   1'b1, 1'b0, 4'd0,  1'b0, 1'b1);
        cyc(OP_R,   1'b1, 1'b0, 4'd1,  1'b0, 1'b0);
        cyc(OP_R,   1'b1, 1'b0, 4'd6,  1'b0, 1'b0);
        cyc(OP_R,   1'b1, 1'b0, 4'd8,  1'b1, 1'b0);
        cyc(OP_I,   1'b1, 1'b0, 4'd0,  1'b0, 1'b1);
        cyc(OP_I,   1'b1, 1'b0, 4'd1,  1'b0, 1'b0);
        cyc(OP_I,   1'b1, 1'b0, 4'd7,  1'b0, 1'b0);
        cyc(OP_I,   1'b1, 1'b0, 4'd8,  1'b1, 1'b0);
        cyc(OP_LW,  1'b1, 1'b0, 4'd0,  1'b0, 1'b1);
        cyc(OP_LW,  1'b1, 1'b0, 4'd1,  1'b0, 1'b0);
        check_eq("immsrc_lw", 32'(ImmSrc), 32'd0);
        cyc(OP_LW,  1'b1, 1'b0, 4'd2,  1'b0, 1'b0);
        cyc(OP_LW,  1'b1, 1'b0, 4'd3,  1'b0, 1'b0);
        cyc(OP_LW,  1'b1, 1'b0, 4'd4,  1'b1, 1'b0);
        cyc(OP_SW,  1'b1, 1'b0, 4'd0,  1'b0, 1'b1);
        cyc(OP_SW,  1'b1, 1'b0, 4'd1,  1'b0, 1'b0);
        check_eq("immsrc_sw", 32'(ImmSrc), 32'd1);
        cyc(OP_SW,  1'b1, 1'b0, 4'd2,  1'b0, 1'b0);
        cyc(OP_SW,  1'b1, 1'b0, 4'd5,  1'b1, 1'b0);
        cyc(OP_JAL, 1'b1, 1'b0, 4'd0,  1'b0, 1'b1);
        cyc(OP_JAL, 1'b1, 1'b0, 4'd1,  1'b0, 1'b0);
        check_eq("immsrc_jal", 32'(ImmSrc), 32'd3);
        cyc(OP_JAL, 1'b1, 1'b0, 4'd10, 1'b0, 1'b1);
        cyc(OP_JAL, 1'b1, 1'b0, 4'd8,  1'b1, 1'b0);
        check_eq("seq_retires",  32'(n_retire),   32'd5);
        check_eq("seq_memwrite", 32'(n_memwrite), 32'd1);

        // beq taken then not taken; both three cycles.
        cyc(OP_BEQ, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1);
        cyc(OP_BEQ, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0);
        check_eq("immsrc_beq", 32'(ImmSrc), 32'd2);
        cyc(OP_BEQ, 1'b1, 1'b1, 4'd9, 1'b1, 1'b1);
        cyc(OP_BEQ, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        cyc(OP_BEQ, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0);
        cyc(OP_BEQ, 1'b1, 1'b0, 4'd9, 1'b1, 1'b0);

        // lw with 2 FETCH and 3 MEMREAD wait cycles: 10 cycles, one IRWrite.
        n_irwrite = 0;
        cyc(OP_LW, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        cyc(OP_LW, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        cyc(OP_LW, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        cyc(OP_LW, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0);
        cyc(OP_LW, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0);
        cyc(OP_LW, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0);
        cyc(OP_LW, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0);
        cyc(OP_LW, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0);
        cyc(OP_LW, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0);
        cyc(OP_LW, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0);
        check_eq("lw_irwrite_once", 32'(n_irwrite), 32'd1);

        // Unsupported opcode locks in TRAP with MemReady and Zero held high.
        cyc(OP_BAD, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1);
        cyc(OP_BAD, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0);
        for (int i = 0; i < 22; i++) begin
            cyc(OP_BAD, 1'b1, 1'b1, 4'd11, 1'b0, 1'b0);
        end
        resetn = 1'b0;
        #1;
        check_reset_outputs("trap_reset");
        @(posedge clk);
        #1;
        resetn = 1'b1;
        cyc(OP_SW, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);

        // sw aborted by reset while waiting for MemReady.
        cyc(OP_SW, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0);
        cyc(OP_SW, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0);
        cyc(OP_SW, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0);
        retire_before = n_retire;
        MemReady = 1'b0;
        #1;
        check_eq("abort_memwrite_before", 32'(MemWrite), 32'd1);
        resetn = 1'b0;
        #1;
        check_eq("abort_memwrite_async", 32'(MemWrite), 32'd0);
        check_reset_outputs("abort");
        @(posedge clk);
        #1;
        resetn = 1'b1;
        cyc(OP_SW, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        cyc(OP_SW, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        cyc(OP_SW, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0);
        check_eq("abort_no_retire", 32'(n_retire), 32'(retire_before));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
